// File: rtl/disp_pkg.sv
// disp_pkg: shared constants, scan state encoding and nibble helpers for the
// 6-digit 7-segment scan controller (display_scan_ctrl, display_tick_gen).
package disp_pkg;

    localparam logic [2:0] SEL_OFF    = 3'b111;   // decoder select code: all digits off
    localparam int         MAX_DIGITS = 6;
    localparam int         NIBBLE_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    // Nibble idx of a 24-bit hex value; digit 0 is the least significant.
    // Out-of-range indices return 0.
    function automatic logic [NIBBLE_W-1:0] nibble_of(input logic [23:0] value,
                                                      input logic [2:0]  idx);
        logic [NIBBLE_W-1:0] nib;
        nib = '0;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (idx == 3'(k)) begin
                nib = value[k*NIBBLE_W +: NIBBLE_W];
            end
        end
        return nib;
    endfunction

    // True when nibbles idx..num_digits-1 of value are all zero, i.e. the
    // digit at idx is a leading zero.
    function automatic logic upper_zero(input logic [23:0] value,
                                        input logic [2:0]  idx,
                                        input int          num_digits);
        logic all_zero;
        all_zero = 1'b1;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if ((k < num_digits) && (3'(k) >= idx) &&
                (value[k*NIBBLE_W +: NIBBLE_W] != '0)) begin
                all_zero = 1'b0;
            end
        end
        return all_zero;
    endfunction

endpackage

// File: rtl/display_tick_gen.sv
// display_tick_gen: per-digit slot counter for the display scan controller.
// Counts 0..SCAN_DIV-1 while enabled and wraps; a synchronous clear forces 0.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   clr         - synchronous clear (priority over en)
//   en          - advance the count this cycle
//   blank_end   - count == BLANK_CYC-1 (never asserted when BLANK_CYC == 0)
//   slot_end    - count == SCAN_DIV-1
module display_tick_gen
    import disp_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic blank_end,
    output logic slot_end
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign slot_end  = (cnt_q == SLOT_LAST);
    assign blank_end = (BLANK_CYC != 0) && (cnt_q == BLANK_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for a 6-digit 7-segment
// display. Latches a 24-bit hex value, snapshots it once per frame to avoid
// tearing, and rotates digit select / nibble towards the downstream decoder.
// Every digit slot opens with BLANK_CYC cycles of all-off to suppress ghosting.
// Optional build macro: LEADING_ZERO_BLANK_EN - blank leading-zero digits
// (digit 0 is always shown); slot timing and frame_done are unaffected.
// Ports:
//   sys_clk, sys_rst - clock and synchronous active-high reset
//   disp_en          - scan enable; low forces all digits off and clears counters
//   data_in          - hex value, digit k = data_in[4k+3:4k]
//   data_load        - one-cycle strobe capturing data_in into the shadow register
//   bit_disp         - registered digit select (3'b111 = all off)
//   data_disp        - registered nibble for the selected digit
//   frame_done       - registered pulse on the final SHOW cycle of the last digit
//
// Handshake: data_load is a plain strobe with no ready; every asserted cycle
// is accepted and the last one before a frame boundary wins.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500,
    parameter int NUM_DIGITS = 6
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        disp_en,
    input  logic [23:0] data_in,
    input  logic        data_load,
    output logic [2:0]  bit_disp,
    output logic [3:0]  data_disp,
    output logic        frame_done
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);
    localparam scan_state_t SLOT_START = (BLANK_CYC == 0) ? SHOW : BLANK;

    scan_state_t state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] shadow_q, shadow_d;
    logic [23:0] active_q, active_d;
    logic [2:0]  bit_disp_q, bit_disp_d;
    logic [3:0]  data_disp_q, data_disp_d;
    logic        frame_done_q, frame_done_d;

    logic blank_end;
    logic slot_end;
    logic frame_end;
    logic snap;
    logic [3:0] cur_nib;

    display_tick_gen #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_tick (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .clr       (~disp_en),
        .en        (state_q != IDLE),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    assign frame_end = (state_q == SHOW) && slot_end && (idx_q == LAST_IDX);
    // The next cycle begins a digit-0 slot: either leaving IDLE or wrapping a frame.
    assign snap      = disp_en && ((state_q == IDLE) || frame_end);
    assign cur_nib   = nibble_of(active_q, idx_q);

    // Next state and digit index
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (disp_en) begin
                    state_d = SLOT_START;
                end
            end
            BLANK: begin
                if (!disp_en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (blank_end) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (!disp_en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (slot_end) begin
                    state_d = SLOT_START;
                    idx_d   = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Shadow / active data path; a load on the snapshot cycle bypasses the shadow.
    always_comb begin
        shadow_d = data_load ? data_in : shadow_q;
        active_d = active_q;
        if (snap) begin
            active_d = data_load ? data_in : shadow_q;
        end
    end

    // Registered outputs, one cycle behind the state/counter they describe.
    // disp_en low blanks immediately rather than waiting for IDLE to register.
    always_comb begin
        bit_disp_d   = SEL_OFF;
        data_disp_d  = '0;
        frame_done_d = 1'b0;
        if (disp_en) begin
            case (state_q)
                BLANK: begin
                    data_disp_d = cur_nib;
                end
                SHOW: begin
                    data_disp_d = cur_nib;
`ifdef LEADING_ZERO_BLANK_EN
                    if ((idx_q != 3'd0) && upper_zero(active_q, idx_q, NUM_DIGITS)) begin
                        bit_disp_d = SEL_OFF;
                    end else begin
                        bit_disp_d = idx_q;
                    end
`else
                    bit_disp_d = idx_q;
`endif
                end
                default: begin
                    data_disp_d = '0;
                end
            endcase
            frame_done_d = frame_end;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            bit_disp_q   <= SEL_OFF;
            data_disp_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            bit_disp_q   <= bit_disp_d;
            data_disp_q  <= data_disp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bit_disp   = bit_disp_q;
    assign data_disp  = data_disp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

    localparam int SCAN_DIV   = 8;
    localparam int BLANK_CYC  = 2;
    localparam int NUM_DIGITS = 6;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    // One digit slot as seen on the outputs: BLANK_CYC cycles of 111 with the
    // nibble, then the select for the rest of the slot; optional load strobe.
    typedef struct {
        logic [2:0]  sel;
        logic [3:0]  nib;
        logic        fd;
        logic        ld;
        logic [23:0] ldv;
        int          ldi;
    } slot_vec_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        disp_en;
    logic [23:0] data_in;
    logic        data_load;
    logic [2:0]  bit_disp;
    logic [3:0]  data_disp;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    slot_vec_t tbl[40];
    int        n_vec = 0;

    // clock / reset block
    always #5 sys_clk = ~sys_clk;

    display_scan_ctrl #(
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_CYC  (BLANK_CYC),
        .NUM_DIGITS (NUM_DIGITS)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .disp_en    (disp_en),
        .data_in    (data_in),
        .data_load  (data_load),
        .bit_disp   (bit_disp),
        .data_disp  (data_disp),
        .frame_done (frame_done)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] eb,
                         input logic [3:0] ed, input logic ef);
        total++;
        if (bit_disp !== eb || data_disp !== ed || frame_done !== ef) begin
            bad++;
            $display("FAIL %s: got bit=%b data=%h fd=%b, want bit=%b data=%h fd=%b",
                     name, bit_disp, data_disp, frame_done, eb, ed, ef);
        end
    endtask

    task automatic add_slot(input int k, input logic [3:0] nib, input logic lz,
                            input logic ld, input logic [23:0] ldv, input int ldi);
        tbl[n_vec].sel = (LZB && lz) ? 3'b111 : 3'(k);
        tbl[n_vec].nib = nib;
        tbl[n_vec].fd  = (k == NUM_DIGITS - 1);
        tbl[n_vec].ld  = ld;
        tbl[n_vec].ldv = ldv;
        tbl[n_vec].ldi = ldi;
        n_vec++;
    endtask

    task automatic run_slot(input string name, input slot_vec_t v, input int nsteps);
        for (int s = 0; s < nsteps; s++) begin
            if (v.ld && s == v.ldi) begin
                data_load = 1'b1;
                data_in   = v.ldv;
            end
            step();
            data_load = 1'b0;
            check(name, (s < BLANK_CYC) ? 3'b111 : v.sel, v.nib,
                  v.fd && (s == SCAN_DIV - 1));
        end
    endtask

    initial begin
        slot_vec_t v;

        // frame 1: 123456
        add_slot(0, 4'h6, 0, 0, 24'h0, 0);
        add_slot(1, 4'h5, 0, 0, 24'h0, 0);
        add_slot(2, 4'h4, 0, 0, 24'h0, 0);
        add_slot(3, 4'h3, 0, 0, 24'h0, 0);
        add_slot(4, 4'h2, 0, 0, 24'h0, 0);
        add_slot(5, 4'h1, 0, 0, 24'h0, 0);
        // frame 2: mid-frame load of ABCDEF must not tear digits 4,5
        add_slot(0, 4'h6, 0, 0, 24'h0, 0);
        add_slot(1, 4'h5, 0, 0, 24'h0, 0);
        add_slot(2, 4'h4, 0, 0, 24'h0, 0);
        add_slot(3, 4'h3, 0, 1, 24'hABCDEF, 3);
        add_slot(4, 4'h2, 0, 0, 24'h0, 0);
        add_slot(5, 4'h1, 0, 0, 24'h0, 0);
        // frame 3: ABCDEF; load 000120 on the snapshot cycle (bypass)
        add_slot(0, 4'hF, 0, 0, 24'h0, 0);
        add_slot(1, 4'hE, 0, 0, 24'h0, 0);
        add_slot(2, 4'hD, 0, 0, 24'h0, 0);
        add_slot(3, 4'hC, 0, 0, 24'h0, 0);
        add_slot(4, 4'hB, 0, 0, 24'h0, 0);
        add_slot(5, 4'hA, 0, 1, 24'h000120, 7);
        // frame 4: 000120, digits 3..5 are leading zeros; load 0 into shadow
        add_slot(0, 4'h0, 0, 1, 24'h000000, 0);
        add_slot(1, 4'h2, 0, 0, 24'h0, 0);
        add_slot(2, 4'h1, 0, 0, 24'h0, 0);
        add_slot(3, 4'h0, 1, 0, 24'h0, 0);
        add_slot(4, 4'h0, 1, 0, 24'h0, 0);
        add_slot(5, 4'h0, 1, 0, 24'h0, 0);
        // frame 5: all zero, only digit 0 survives blanking; bypass-load 654321
        add_slot(0, 4'h0, 0, 0, 24'h0, 0);
        add_slot(1, 4'h0, 1, 0, 24'h0, 0);
        add_slot(2, 4'h0, 1, 0, 24'h0, 0);
        add_slot(3, 4'h0, 1, 0, 24'h0, 0);
        add_slot(4, 4'h0, 1, 0, 24'h0, 0);
        add_slot(5, 4'h0, 1, 1, 24'h654321, 7);
        // frame 6: first two digits of 654321
        add_slot(0, 4'h1, 0, 0, 24'h0, 0);
        add_slot(1, 4'h2, 0, 0, 24'h0, 0);

        // reset and idle hold, including a load while idle
        sys_rst   = 1'b1;
        disp_en   = 1'b0;
        data_load = 1'b0;
        data_in   = 24'h0;
        step();
        step();
        check("reset", 3'b111, 4'h0, 1'b0);
        sys_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_hold", 3'b111, 4'h0, 1'b0);
        end
        data_load = 1'b1;
        data_in   = 24'h123456;
        step();
        data_load = 1'b0;
        data_in   = 24'($urandom_range(0, 255));
        check("idle_load", 3'b111, 4'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_after_load", 3'b111, 4'h0, 1'b0);
        end

        // enable: first edge still reflects IDLE
        disp_en = 1'b1;
        step();
        check("enable_edge", 3'b111, 4'h0, 1'b0);

        for (int i = 0; i < n_vec; i++) begin
            run_slot($sformatf("slot%0d", i), tbl[i], SCAN_DIV);
        end

        // disp_en dropped during SHOW of digit 2
        v = '{sel: 3'd2, nib: 4'h3, fd: 1'b0, ld: 1'b0, ldv: 24'h0, ldi: 0};
        run_slot("digit2_pre_drop", v, 3);
        disp_en = 1'b0;
        step();
        check("drop_off", 3'b111, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("dropped_idle", 3'b111, 4'h0, 1'b0);
        end
        disp_en = 1'b1;
        step();
        check("reenable_edge", 3'b111, 4'h0, 1'b0);
        v = '{sel: 3'd0, nib: 4'h1, fd: 1'b0, ld: 1'b0, ldv: 24'h0, ldi: 0};
        run_slot("restart_d0", v, SCAN_DIV);
        v = '{sel: 3'd1, nib: 4'h2, fd: 1'b0, ld: 1'b0, ldv: 24'h0, ldi: 0};
        run_slot("restart_d1", v, 4);

        // reset mid-slot with a coincident load that must be lost
        sys_rst   = 1'b1;
        data_load = 1'b1;
        data_in   = 24'h999999;
        step();
        check("mid_reset", 3'b111, 4'h0, 1'b0);
        sys_rst   = 1'b0;
        data_load = 1'b0;
        step();
        check("post_reset_edge", 3'b111, 4'h0, 1'b0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            v.sel = (LZB && k > 0) ? 3'b111 : 3'(k);
            v.nib = 4'h0;
            v.fd  = (k == NUM_DIGITS - 1);
            v.ld  = 1'b0;
            v.ldv = 24'h0;
            v.ldi = 0;
            run_slot($sformatf("post_reset_d%0d", k), v, SCAN_DIV);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
